// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } regfile_state_t;

   function automatic int regfile_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int DEFAULT_DEPTH      = regfile_depth(DEFAULT_ADDR_WIDTH);

   // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
   function automatic int port_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry writing zero, then hands the
// array write port over to the writeback stage.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] writeback_address,
   input  logic [DATA_WIDTH-1:0] writeback_data,
   input  logic                  writeback_enable,
   output regfile_state_t        state,
   output logic                  init_busy,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = {ADDR_WIDTH{1'b1}};

   regfile_state_t        state_reg, state_next;
   logic [ADDR_WIDTH-1:0] clear_cnt_reg, clear_cnt_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= CLEAR;
         clear_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         clear_cnt_reg <= clear_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      clear_cnt_next = clear_cnt_reg;
      case (state_reg)
         CLEAR: begin
            clear_cnt_next = clear_cnt_reg + ADDR_WIDTH'(1);
            if (clear_cnt_reg == LAST_ENTRY) begin
               state_next = READY;
            end
         end
         READY:   state_next = READY;
         default: state_next = CLEAR;
      endcase
   end

   // Writebacks are dropped while clearing; address 0 is never stored.
   always_comb begin
      state     = state_reg;
      init_busy = (state_reg == CLEAR);
      mem_we    = 1'b0;
      mem_waddr = writeback_address;
      mem_wdata = writeback_data;
      if (state_reg == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clear_cnt_reg;
         mem_wdata = '0;
      end else begin
         mem_we    = writeback_enable && (writeback_address != '0);
      end
   end

endmodule

// File: rtl/multiport_register_file.sv
// NUM_READ-port register file with hardwired r0, write-to-read forwarding and
// post-reset clearing. Define REGFILE_SCOREBOARD_EN for per-register pending bits.
module multiport_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
   input  logic [ADDR_WIDTH-1:0]          writeback_address,
   input  logic [DATA_WIDTH-1:0]          writeback_data,
   input  logic                           writeback_enable,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic [ADDR_WIDTH-1:0]          reserve_address,
   input  logic                           reserve_enable,
   output logic [NUM_READ-1:0]            rd_pending,
`endif
   output logic                           init_busy
);

   localparam int DEPTH = regfile_depth(ADDR_WIDTH);

   regfile_state_t        state;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   regfile_clear_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clock             (clock),
      .reset             (reset),
      .writeback_address (writeback_address),
      .writeback_data    (writeback_data),
      .writeback_enable  (writeback_enable),
      .state             (state),
      .init_busy         (init_busy),
      .mem_we            (mem_we),
      .mem_waddr         (mem_waddr),
      .mem_wdata         (mem_wdata)
   );

   // Storage itself is not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
         logic [ADDR_WIDTH-1:0] addr;
         logic [DATA_WIDTH-1:0] rd_data_reg;

         assign addr = rd_addr[port_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               rd_data_reg <= '0;
            end else if (enable) begin
               if (state == CLEAR || addr == '0) begin
                  rd_data_reg <= '0;
               end else if (writeback_enable && writeback_address == addr) begin
                  rd_data_reg <= writeback_data;
               end else begin
                  rd_data_reg <= mem[addr];
               end
            end
         end

         assign rd_data[port_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = rd_data_reg;
      end
   endgenerate

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] pending_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
         logic set_hit;
         logic clr_hit;

         assign set_hit = reserve_enable && (reserve_address == ADDR_WIDTH'(gi))
                          && (reserve_address != '0);
         assign clr_hit = writeback_enable && (writeback_address == ADDR_WIDTH'(gi));

         // A reserve in the same cycle as a writeback of the same register wins.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               pending_reg[gi] <= 1'b0;
            end else if (state == CLEAR) begin
               pending_reg[gi] <= 1'b0;
            end else if (set_hit) begin
               pending_reg[gi] <= 1'b1;
            end else if (clr_hit) begin
               pending_reg[gi] <= 1'b0;
            end
         end
      end

      for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_pend_out
         logic [ADDR_WIDTH-1:0] paddr;
         assign paddr = rd_addr[port_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
         assign rd_pending[gi] = pending_reg[paddr]
                                 & ~(writeback_enable & (writeback_address == paddr))
                                 & (paddr != '0);
      end
   endgenerate
`endif

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (default 32x32, 2 read ports).
module tb_multiport_register_file;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [4:0]  writeback_address = '0;
   logic [31:0] writeback_data = '0;
   logic        writeback_enable = 1'b0;
   logic        init_busy;
   logic [4:0]  reserve_address = '0;
   logic        reserve_enable = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
   logic [1:0]  rd_pending;
`endif

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Reference model: architectural register contents and clear progress.
   logic [31:0] model_mem [32];
   logic [31:0] exp_rd [2];
   int          clear_left;

   typedef struct {
      logic        en;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vecs [10];

   always #5 clock = ~clock;

   multiport_register_file #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .NUM_READ   (2)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .writeback_address (writeback_address),
      .writeback_data    (writeback_data),
      .writeback_enable  (writeback_enable),
`ifdef REGFILE_SCOREBOARD_EN
      .reserve_address   (reserve_address),
      .reserve_enable    (reserve_enable),
      .rd_pending        (rd_pending),
`endif
      .init_busy         (init_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      exp_rd[0]  = '0;
      exp_rd[1]  = '0;
      clear_left = 32;
   endtask

   // Drive one cycle of inputs, predict, clock, then compare.
   task automatic cycle(input logic en, input logic [4:0] a0, input logic [4:0] a1,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      logic [4:0] a;
      enable            = en;
      rd_addr           = {a1, a0};
      writeback_enable  = we;
      writeback_address = wa;
      writeback_data    = wd;
      for (int p = 0; p < 2; p++) begin
         a = (p == 0) ? a0 : a1;
         if (en) begin
            if (clear_left > 0 || a == 0) exp_rd[p] = '0;
            else if (we && wa == a)       exp_rd[p] = wd;
            else                          exp_rd[p] = model_mem[a];
         end
      end
      if (clear_left > 0) clear_left--;
      else if (we && wa != 0) model_mem[wa] = wd;
      @(posedge clock);
      #1;
      check("rd0", rd_data[31:0], exp_rd[0]);
      check("rd1", rd_data[63:32], exp_rd[1]);
      check("busy", {31'b0, init_busy}, {31'b0, (clear_left > 0)});
      txn++;
      $display("txn %0d en=%0b a0=%0d a1=%0d we=%0b wa=%0d wd=%h rd0=%h rd1=%h busy=%0b",
               txn, en, a0, a1, we, wa, wd, rd_data[31:0], rd_data[63:32], init_busy);
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (init_busy && n < 100) begin
         cycle(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0);
         n++;
      end
      check(name, n, 32);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd7,  32'hDEADBEEF, 32'h0,        32'h0};
      vecs[1] = '{1'b1, 5'd7, 5'd7, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd3, 5'd3, 1'b1, 5'd3,  32'h12345678, 32'h12345678, 32'h12345678};
      vecs[3] = '{1'b1, 5'd0, 5'd3, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h12345678};
      vecs[4] = '{1'b1, 5'd4, 5'd7, 1'b1, 5'd4,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF};
      vecs[5] = '{1'b0, 5'd4, 5'd4, 1'b1, 5'd4,  32'h11111111, 32'hA5A5A5A5, 32'hDEADBEEF};
      vecs[6] = '{1'b0, 5'd4, 5'd3, 1'b0, 5'd0,  32'h0,        32'hA5A5A5A5, 32'hDEADBEEF};
      vecs[7] = '{1'b1, 5'd4, 5'd0, 1'b0, 5'd0,  32'h0,        32'h11111111, 32'h0};
      vecs[8] = '{1'b1, 5'd1, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 32'h0,       32'hCAFEF00D};
      vecs[9] = '{1'b1, 5'd31, 5'd0, 1'b0, 5'd0,  32'h0,        32'hCAFEF00D, 32'h0};

      // Reset held for 3 cycles, checked while asserted.
      model_reset();
      #1;
      check("reset_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
      check("reset_busy", {31'b0, init_busy}, 32'h1);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      count_busy("busy_len");

      // Every register reads zero after the clear.
      for (int i = 0; i < 32; i += 2) begin
         cycle(1'b1, 5'(i), 5'(i + 1), 1'b0, 5'd0, 32'h0);
         check("clr_rd0", rd_data[31:0], 32'h0);
         check("clr_rd1", rd_data[63:32], 32'h0);
      end

      // Directed vector table: write, forward, r0, read hold.
      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].en, vecs[i].a0, vecs[i].a1, vecs[i].we, vecs[i].wa, vecs[i].wd);
         check("vec_rd0", rd_data[31:0], vecs[i].e0);
         check("vec_rd1", rd_data[63:32], vecs[i].e1);
      end

`ifdef REGFILE_SCOREBOARD_EN
      reserve_address = 5'd9;
      reserve_enable  = 1'b1;
      cycle(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0);
      reserve_enable  = 1'b0;
      #1;
      check("pend_set", {30'b0, rd_pending}, 32'h3);
      reserve_enable  = 1'b1;
      cycle(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99);
      reserve_enable   = 1'b0;
      writeback_enable = 1'b0;
      #1;
      check("pend_set_wins", {30'b0, rd_pending}, 32'h3);
      writeback_enable = 1'b1;
      #1;
      check("pend_comb_clr", {30'b0, rd_pending}, 32'h0);
      cycle(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 32'h77);
      writeback_enable = 1'b0;
      #1;
      check("pend_cleared", {30'b0, rd_pending}, 32'h0);
`endif

      // Randomised traffic against the model; narrow addresses force collisions.
      for (int i = 0; i < 300; i++) begin
         logic [4:0] ra0, ra1, wa;
         ra0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         wa  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         cycle($urandom_range(0, 4) != 0, ra0, ra1, $urandom_range(0, 1) == 1, wa, $urandom);
      end

      // Reset mid-clear with writebacks to r5 that must be dropped.
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cycle(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 32'h5555AAAA);
      reset = 1'b1;
      #1;
      check("midclr_busy", {31'b0, init_busy}, 32'h1);
      check("midclr_rd", rd_data[31:0], 32'h0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      count_busy("busy_restart_len");
      cycle(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
      check("r5_after_clear", rd_data[31:0], 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
